// File: rtl/pipe_hazard_sched.sv
// Hazard scheduler for a 5-stage pipeline: load-use stall, branch flush window,
// EX operand forwarding selects and saturating stall/flush performance counters.
module pipe_hazard_sched #(
  parameter int REG_W        = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16   // counters saturate at 2**CNT_W-1 (1..16)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state_o,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
);

  localparam logic [1:0]  ST_RUN     = 2'b00;
  localparam logic [1:0]  ST_STALL   = 2'b01;
  localparam logic [1:0]  ST_FLUSH   = 2'b10;
  localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] CNT_MAX    = 16'((32'd1 << CNT_W) - 32'd1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        use_rs1, use_rs2, load_use;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v >= CNT_MAX) ? v : v + 16'd1;
  endfunction

  // EX/MEM wins over MEM/WB because it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] m_rd, input logic m_wr,
    input logic [REG_W-1:0] w_rd, input logic w_wr
  );
    if (m_wr && m_rd != '0 && m_rd == rs) return 2'b01;
    if (w_wr && w_rd != '0 && w_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode)
      4'b0001, 4'b0010, 4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1111: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b1110: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((use_rs1 && ex_rd == id_rs1) || (use_rs2 && ex_rd == id_rs2));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = ST_RUN;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    fwd_a       = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    fwd_b       = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);

    case (state_q)
      ST_FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (fcnt_q <= 4'd1) begin
          fcnt_d = '0;
        end else begin
          state_d = ST_FLUSH;
          fcnt_d  = fcnt_q - 4'd1;
        end
      end
      default: begin
        // Branch outranks load-use; STALL never re-arms a stall.
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_cnt_d = sat_inc(flush_cnt_q);
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            fcnt_d = '0;
          end
        end else if (state_q == ST_RUN && load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_cnt_d = sat_inc(stall_cnt_q);
          state_d     = ST_STALL;
        end
      end
    endcase

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a       = 2'b00;
      fwd_b       = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    if (rst) begin
      state_q     <= ST_RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state_o   = rst ? ST_RUN : state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Bench for pipe_hazard_sched: directed scenarios plus a randomized run against a
// cycle-level reference model; a second instance (FLUSH_CYCLES=1, 3-bit counters) covers saturation.
module tb_pipe_hazard_sched;
  localparam int REG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]       id_opcode;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic             ex_mem_read, mem_reg_write, wb_reg_write, branch_taken;

  logic        pc_w [2], ifw_w [2], fl_w [2], bub_w [2];
  logic [1:0]  fa_w [2], fb_w [2], st_w [2];
  logic [15:0] scnt_w [2], fcnt_w [2];
  logic [3:0]  ctl [2];   // {pc_write, ifid_write, ifid_flush, idex_bubble}

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_sched #(.REG_W(REG_W), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .pc_write(pc_w[0]), .ifid_write(ifw_w[0]),
    .ifid_flush(fl_w[0]), .idex_bubble(bub_w[0]), .fwd_a(fa_w[0]), .fwd_b(fb_w[0]),
    .state_o(st_w[0]), .stall_cnt(scnt_w[0]), .flush_cnt(fcnt_w[0]));

  pipe_hazard_sched #(.REG_W(REG_W), .FLUSH_CYCLES(1), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .pc_write(pc_w[1]), .ifid_write(ifw_w[1]),
    .ifid_flush(fl_w[1]), .idex_bubble(bub_w[1]), .fwd_a(fa_w[1]), .fwd_b(fb_w[1]),
    .state_o(st_w[1]), .stall_cnt(scnt_w[1]), .flush_cnt(fcnt_w[1]));

  assign ctl[0] = {pc_w[0], ifw_w[0], fl_w[0], bub_w[0]};
  assign ctl[1] = {pc_w[1], ifw_w[1], fl_w[1], bub_w[1]};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    id_opcode = '0; id_rs1 = '0; id_rs2 = '0; ex_rd = '0; ex_mem_read = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; mem_rd = '0; mem_reg_write = 1'b0;
    wb_rd = '0; wb_reg_write = 1'b0; branch_taken = 1'b0;
  endtask

  // LW r3 in EX, ADD r1,r3 in ID
  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 4'd3; id_opcode = 4'b0001; id_rs1 = 4'd1; id_rs2 = 4'd3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    set_load_use();
    branch_taken = 1'b1; mem_rd = 4'd4; mem_reg_write = 1'b1; ex_rs1 = 4'd4; ex_rs2 = 4'd4;
    settle();
    n_checks++; if (ctl[0] !== 4'b0011) begin n_fail++; $display("FAIL reset_ctl got=%b exp=0011", ctl[0]); end
    n_checks++; if (fa_w[0] !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_a got=%b exp=00", fa_w[0]); end
    n_checks++; if (fb_w[0] !== 2'b00) begin n_fail++; $display("FAIL reset_fwd_b got=%b exp=00", fb_w[0]); end
    n_checks++; if (st_w[0] !== 2'b00) begin n_fail++; $display("FAIL reset_state got=%b exp=00", st_w[0]); end
    tick();
    settle();
    n_checks++; if (scnt_w[0] !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", scnt_w[0]); end
    n_checks++; if (fcnt_w[0] !== 16'd0) begin n_fail++; $display("FAIL reset_flush_cnt got=%0d exp=0", fcnt_w[0]); end
    n_checks++; if (ctl[1] !== 4'b0011) begin n_fail++; $display("FAIL reset_ctl_small got=%b exp=0011", ctl[1]); end
    rst = 1'b0;
    idle();
    settle();
    n_checks++; if (ctl[0] !== 4'b1100) begin n_fail++; $display("FAIL run_idle_ctl got=%b exp=1100", ctl[0]); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_load_use();
    settle();
    n_checks++; if (ctl[0] !== 4'b0001) begin n_fail++; $display("FAIL lu_stall_ctl got=%b exp=0001", ctl[0]); end
    n_checks++; if (st_w[0] !== 2'b00) begin n_fail++; $display("FAIL lu_state_run got=%b exp=00", st_w[0]); end
    tick();
    settle();
    n_checks++; if (st_w[0] !== 2'b01) begin n_fail++; $display("FAIL lu_state_stall got=%b exp=01", st_w[0]); end
    n_checks++; if (ctl[0] !== 4'b1100) begin n_fail++; $display("FAIL lu_no_retrigger got=%b exp=1100", ctl[0]); end
    n_checks++; if (scnt_w[0] !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d exp=1", scnt_w[0]); end
    idle();
    tick();
    settle();
    n_checks++; if (st_w[0] !== 2'b00) begin n_fail++; $display("FAIL lu_back_to_run got=%b exp=00", st_w[0]); end
    n_checks++; if (scnt_w[0] !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt_hold got=%0d exp=1", scnt_w[0]); end
  endtask

  task automatic test_unused_src();
    logic [3:0] op  [8] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0001, 4'b1110, 4'b0111, 4'b1111};
    logic [3:0] rs1 [8] = '{4'd5, 4'd3, 4'd3, 4'd0, 4'd3, 4'd3, 4'd3, 4'd2};
    logic [3:0] rs2 [8] = '{4'd3, 4'd5, 4'd3, 4'd0, 4'd3, 4'd0, 4'd3, 4'd3};
    logic [3:0] erd [8] = '{4'd3, 4'd3, 4'd3, 4'd0, 4'd3, 4'd3, 4'd3, 4'd3};
    logic       lw  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       stl [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      idle();
      id_opcode = op[i]; id_rs1 = rs1[i]; id_rs2 = rs2[i]; ex_rd = erd[i]; ex_mem_read = lw[i];
      settle();
      n_checks++;
      if (ctl[0] !== (stl[i] ? 4'b0001 : 4'b1100)) begin
        n_fail++;
        $display("FAIL src_use_%0d got=%b exp=%b", i, ctl[0], stl[i] ? 4'b0001 : 4'b1100);
      end
      idle();
      tick();
      tick();
    end
  endtask

  task automatic test_branch_priority();
    do_reset();
    set_load_use();
    branch_taken = 1'b1;
    settle();
    n_checks++; if (ctl[0] !== 4'b1111) begin n_fail++; $display("FAIL br_resolve_ctl got=%b exp=1111", ctl[0]); end
    tick();
    settle();
    n_checks++; if (st_w[0] !== 2'b10) begin n_fail++; $display("FAIL br_state_flush got=%b exp=10", st_w[0]); end
    n_checks++; if (ctl[0] !== 4'b1111) begin n_fail++; $display("FAIL br_flush2_ctl got=%b exp=1111", ctl[0]); end
    tick();
    idle();
    settle();
    n_checks++; if (st_w[0] !== 2'b00) begin n_fail++; $display("FAIL br_back_to_run got=%b exp=00", st_w[0]); end
    n_checks++; if (ctl[0] !== 4'b1100) begin n_fail++; $display("FAIL br_window_end got=%b exp=1100", ctl[0]); end
    n_checks++; if (fcnt_w[0] !== 16'd1) begin n_fail++; $display("FAIL br_flush_cnt got=%0d exp=1", fcnt_w[0]); end
    n_checks++; if (scnt_w[0] !== 16'd0) begin n_fail++; $display("FAIL br_stall_cnt got=%0d exp=0", scnt_w[0]); end
  endtask

  // Counters continue from test_branch_priority: stall 0, flush 1.
  task automatic test_branch_in_stall();
    set_load_use();
    tick();
    branch_taken = 1'b1;
    settle();
    n_checks++; if (st_w[0] !== 2'b01) begin n_fail++; $display("FAIL bs_state_stall got=%b exp=01", st_w[0]); end
    n_checks++; if (ctl[0] !== 4'b1111) begin n_fail++; $display("FAIL bs_ctl got=%b exp=1111", ctl[0]); end
    tick();
    idle();
    settle();
    n_checks++; if (st_w[0] !== 2'b10) begin n_fail++; $display("FAIL bs_state_flush got=%b exp=10", st_w[0]); end
    n_checks++; if (fcnt_w[0] !== 16'd2) begin n_fail++; $display("FAIL bs_flush_cnt got=%0d exp=2", fcnt_w[0]); end
    n_checks++; if (scnt_w[0] !== 16'd1) begin n_fail++; $display("FAIL bs_stall_cnt got=%0d exp=1", scnt_w[0]); end
    tick();
  endtask

  task automatic test_forwarding();
    // {mem_rd, mem_wr, wb_rd, wb_wr, ex_rs1, ex_rs2, exp_a, exp_b}
    logic [3:0] mrd [6] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd0};
    logic       mwr [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] wrd [6] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd6, 4'd0};
    logic       wwr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] rsa [6] = '{4'd4, 4'd4, 4'd0, 4'd4, 4'd6, 4'd0};
    logic [3:0] rsb [6] = '{4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd0};
    logic [1:0] ea  [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00};
    logic [1:0] eb  [6] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 6; i++) begin
      idle();
      mem_rd = mrd[i]; mem_reg_write = mwr[i]; wb_rd = wrd[i]; wb_reg_write = wwr[i];
      ex_rs1 = rsa[i]; ex_rs2 = rsb[i];
      branch_taken = (i == 4);   // row 5 is sampled while in FLUSH
      settle();
      n_checks++; if (fa_w[0] !== ea[i]) begin n_fail++; $display("FAIL fwd_a_%0d got=%b exp=%b", i, fa_w[0], ea[i]); end
      n_checks++; if (fb_w[0] !== eb[i]) begin n_fail++; $display("FAIL fwd_b_%0d got=%b exp=%b", i, fb_w[0], eb[i]); end
      tick();
    end
    idle();
    mem_rd = 4'd7; mem_reg_write = 1'b1; ex_rs1 = 4'd7;
    branch_taken = 1'b1;
    tick();
    settle();
    n_checks++; if (st_w[0] !== 2'b10) begin n_fail++; $display("FAIL fwd_in_flush_state got=%b exp=10", st_w[0]); end
    n_checks++; if (fa_w[0] !== 2'b01) begin n_fail++; $display("FAIL fwd_in_flush got=%b exp=01", fa_w[0]); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_load_use();
    tick();
    idle();
    tick();
    branch_taken = 1'b1;
    tick();
    rst = 1'b1;
    idle();
    settle();
    n_checks++; if (ctl[0] !== 4'b0011) begin n_fail++; $display("FAIL rf_ctl_in_rst got=%b exp=0011", ctl[0]); end
    n_checks++; if (st_w[0] !== 2'b00) begin n_fail++; $display("FAIL rf_state_in_rst got=%b exp=00", st_w[0]); end
    tick();
    settle();
    n_checks++; if (scnt_w[0] !== 16'd0) begin n_fail++; $display("FAIL rf_stall_cnt got=%0d exp=0", scnt_w[0]); end
    n_checks++; if (fcnt_w[0] !== 16'd0) begin n_fail++; $display("FAIL rf_flush_cnt got=%0d exp=0", fcnt_w[0]); end
    n_checks++; if (pc_w[0] !== 1'b0) begin n_fail++; $display("FAIL rf_pc_write_held got=%b exp=0", pc_w[0]); end
    rst = 1'b0;
    set_load_use();
    settle();
    n_checks++; if (ctl[0] !== 4'b0001) begin n_fail++; $display("FAIL rf_first_run got=%b exp=0001", ctl[0]); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_load_use();
    tick();
    rst = 1'b1;
    settle();
    n_checks++; if (st_w[0] !== 2'b00) begin n_fail++; $display("FAIL rs_state_in_rst got=%b exp=00", st_w[0]); end
    tick();
    rst = 1'b0;
    settle();
    n_checks++; if (ctl[0] !== 4'b0001) begin n_fail++; $display("FAIL rs_first_run got=%b exp=0001", ctl[0]); end
    n_checks++; if (scnt_w[0] !== 16'd0) begin n_fail++; $display("FAIL rs_stall_cnt got=%0d exp=0", scnt_w[0]); end
    idle();
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_load_use();
      tick();
      idle();
      tick();
    end
    settle();
    n_checks++; if (scnt_w[0] !== 16'd9) begin n_fail++; $display("FAIL b2b_stall_cnt got=%0d exp=9", scnt_w[0]); end
    n_checks++; if (scnt_w[1] !== 16'd7) begin n_fail++; $display("FAIL sat_stall_cnt got=%0d exp=7", scnt_w[1]); end
    branch_taken = 1'b1;
    settle();
    n_checks++; if (ctl[1] !== 4'b1111) begin n_fail++; $display("FAIL fc1_resolve_ctl got=%b exp=1111", ctl[1]); end
    for (int i = 0; i < 9; i++) tick();
    settle();
    n_checks++; if (st_w[1] !== 2'b00) begin n_fail++; $display("FAIL fc1_state got=%b exp=00", st_w[1]); end
    n_checks++; if (st_w[0] !== 2'b10) begin n_fail++; $display("FAIL b2b_state got=%b exp=10", st_w[0]); end
    n_checks++; if (fcnt_w[0] !== 16'd5) begin n_fail++; $display("FAIL b2b_flush_cnt got=%0d exp=5", fcnt_w[0]); end
    n_checks++; if (fcnt_w[1] !== 16'd7) begin n_fail++; $display("FAIL sat_flush_cnt got=%0d exp=7", fcnt_w[1]); end
    idle();
    tick();
    tick();
  endtask

  // Reference model: mode 0 RUN, 1 STALL, 2 FLUSH; rem = flush slots still owed.
  task automatic test_random();
    int fc   [2] = '{2, 1};
    int cmax [2] = '{65535, 7};
    int mode [2], rem [2], nst [2], nfl [2];
    bit lu, u1, u2, flushing, stalling;
    logic [3:0] exp_ctl;
    logic [1:0] exp_a, exp_b;
    for (int k = 0; k < 2; k++) begin mode[k] = 0; rem[k] = 0; nst[k] = 0; nfl[k] = 0; end
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst           = ($urandom_range(0, 79) == 0);
      id_opcode     = 4'($urandom_range(0, 15));
      id_rs1        = REG_W'($urandom_range(0, 3));
      id_rs2        = REG_W'($urandom_range(0, 3));
      ex_rd         = REG_W'($urandom_range(0, 3));
      ex_mem_read   = 1'($urandom_range(0, 1));
      ex_rs1        = REG_W'($urandom_range(0, 3));
      ex_rs2        = REG_W'($urandom_range(0, 3));
      mem_rd        = REG_W'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_rd         = REG_W'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 5) == 0);
      settle();
      u2 = id_opcode inside {4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd13, 4'd15};
      u1 = u2 || (id_opcode inside {4'd3, 4'd4, 4'd5, 4'd6, 4'd14});
      lu = ex_mem_read && ex_rd != 0 && ((u1 && ex_rd == id_rs1) || (u2 && ex_rd == id_rs2));
      exp_a = (mem_reg_write && mem_rd != 0 && mem_rd == ex_rs1) ? 2'b01 :
              (wb_reg_write && wb_rd != 0 && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
      exp_b = (mem_reg_write && mem_rd != 0 && mem_rd == ex_rs2) ? 2'b01 :
              (wb_reg_write && wb_rd != 0 && wb_rd == ex_rs2) ? 2'b10 : 2'b00;
      for (int k = 0; k < 2; k++) begin
        flushing = (mode[k] == 2) || branch_taken;
        stalling = !flushing && mode[k] == 0 && lu;
        exp_ctl  = rst ? 4'b0011 : {!stalling, !stalling, flushing, flushing || stalling};
        n_checks++; if (ctl[k] !== exp_ctl) begin n_fail++; $display("FAIL rnd_ctl[%0d] cyc=%0d got=%b exp=%b", k, cyc, ctl[k], exp_ctl); end
        n_checks++; if (fa_w[k] !== (rst ? 2'b00 : exp_a)) begin n_fail++; $display("FAIL rnd_fwd_a[%0d] cyc=%0d got=%b exp=%b", k, cyc, fa_w[k], rst ? 2'b00 : exp_a); end
        n_checks++; if (fb_w[k] !== (rst ? 2'b00 : exp_b)) begin n_fail++; $display("FAIL rnd_fwd_b[%0d] cyc=%0d got=%b exp=%b", k, cyc, fb_w[k], rst ? 2'b00 : exp_b); end
        n_checks++; if (st_w[k] !== (rst ? 2'b00 : 2'(mode[k]))) begin n_fail++; $display("FAIL rnd_state[%0d] cyc=%0d got=%b exp=%0d", k, cyc, st_w[k], rst ? 0 : mode[k]); end
        n_checks++; if (scnt_w[k] !== 16'(nst[k])) begin n_fail++; $display("FAIL rnd_stall_cnt[%0d] cyc=%0d got=%0d exp=%0d", k, cyc, scnt_w[k], nst[k]); end
        n_checks++; if (fcnt_w[k] !== 16'(nfl[k])) begin n_fail++; $display("FAIL rnd_flush_cnt[%0d] cyc=%0d got=%0d exp=%0d", k, cyc, fcnt_w[k], nfl[k]); end
        if (rst) begin
          mode[k] = 0; rem[k] = 0; nst[k] = 0; nfl[k] = 0;
        end else if (mode[k] == 2) begin
          rem[k]--;
          if (rem[k] <= 0) mode[k] = 0;
        end else if (branch_taken) begin
          if (nfl[k] < cmax[k]) nfl[k]++;
          rem[k]  = fc[k] - 1;
          mode[k] = (rem[k] > 0) ? 2 : 0;
        end else if (stalling) begin
          if (nst[k] < cmax[k]) nst[k]++;
          mode[k] = 1;
        end else begin
          mode[k] = 0;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_unused_src();
    test_branch_priority();
    test_branch_in_stall();
    test_forwarding();
    test_reset_mid_flush();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
